// File: rtl/fa32_pipe_arb.sv
// ---------------------------------------------------------------------------
// fa32_pipe_arb
//   Round-robin front end for an external fixed-latency 32-bit pipelined
//   adder. One requester is granted per cycle. Its operands are registered
//   towards the adder, and a tag pipe carries {valid, id} alongside the
//   adder. Each result is returned as a one-cycle response, in issue order.
//
// Parameters
//   LAT   adder latency in clk edges from add_* sampled to add_s valid (1..16)
//   NREQ  number of requesters (4 in this revision)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   issue enable (low blocks new grants)
//   req/req_a/req_b/req_cin  per-requester request and operands (lane i = bits 32i+:32)
//   gnt                  one-hot combinational grant
//   add_a/add_b/add_cin  registered operands to the adder
//   add_s/add_cout       adder result, aligned with tag stage LAT
//   rsp_valid/rsp_id/rsp_sum/rsp_cout  registered response
//   busy                 high while the FSM is not IDLE
//   ovf_cnt              saturating count of results with carry-out
//                        (only when FA32_ARB_STATS_EN is defined)
// ---------------------------------------------------------------------------
module fa32_pipe_arb #(
  parameter int unsigned LAT  = 8,
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_s,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout,
`ifdef FA32_ARB_STATS_EN
  output logic [15:0]          ovf_cnt,
`endif
  output logic                 busy
);

  localparam int unsigned IDW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_hit;
  logic            arb_allow;
  logic            accept;

  logic [31:0]     sel_a, sel_b;
  logic            sel_cin;
  logic [31:0]     add_a_q, add_b_q;
  logic            add_cin_q;

  logic [LAT:0]    tag_v_q;
  logic [IDW-1:0]  tag_id_q [0:LAT];
  logic            tag_any;

  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_sum_q;
  logic            rsp_cout_q;

  // -------------------------------------------------------------------------
  // Round-robin search starting at ptr_q.
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    gnt_hit = 1'b0;
    for (int off = 0; off < int'(NREQ); off++) begin
      cand = IDW'((int'(ptr_q) + off) % int'(NREQ));
      if (!gnt_hit && req[cand]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // rst_n gates the grant so gnt reads zero for the whole reset period,
  // even when en and req are already high.
  assign arb_allow = rst_n && en && (state_q != DRAIN);
  assign accept    = arb_allow && gnt_hit;

  always_comb begin
    gnt = '0;
    if (accept) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = IDW'((int'(gnt_idx) + 1) % int'(NREQ));
  end

  // Operand mux for the granted lane.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_cin = req_cin[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Issue registers, arbiter pointer, FSM state.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        add_a_q   <= sel_a;
        add_b_q   <= sel_b;
        add_cin_q <= sel_cin;
      end
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;

  // -------------------------------------------------------------------------
  // Tag pipe: stage 0 loads on the accepting edge, stage LAT lines up with
  // add_s/add_cout. It shifts every edge and never stalls.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_v_q <= '0;
    else        tag_v_q <= {tag_v_q[LAT-1:0], accept};
  end

  // NOTE: the id payload is deliberately left without reset. The valid bits
  // qualify it, so clearing them is enough to discard in-flight work.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= gnt_idx;
    for (int i = 1; i <= int'(LAT); i++) tag_id_q[i] <= tag_id_q[i-1];
  end

  assign tag_any = |tag_v_q;

  // -------------------------------------------------------------------------
  // Response registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      rsp_valid_q <= tag_v_q[LAT];
      if (tag_v_q[LAT]) begin
        rsp_id_q   <= tag_id_q[LAT];
        rsp_sum_q  <= add_s;
        rsp_cout_q <= add_cout;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

  // -------------------------------------------------------------------------
  // Control FSM. The next rsp_valid equals tag_v_q[LAT]. An empty tag pipe
  // before the edge therefore means no response remains pending after it,
  // and busy drops on the edge that ends the last response pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE: begin
        if (!en && tag_any)          state_d = DRAIN;
        else if (!tag_any && !accept) state_d = IDLE;
      end
      DRAIN:   if (!tag_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef FA32_ARB_STATS_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           ovf_cnt_q <= '0;
    else if (tag_v_q[LAT] && add_cout && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fa32_pipe_arb.sv
// ---------------------------------------------------------------------------
// tb_fa32_pipe_arb
//   Directed bench for fa32_pipe_arb with a behavioural LAT-stage adder.
//   The expected response, including its arrival cycle, is queued at each
//   grant and compared when rsp_valid fires.
// ---------------------------------------------------------------------------
module tb_fa32_pipe_arb;

  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    req;
  logic [127:0]  req_a, req_b;
  logic [3:0]    req_cin;
  logic [3:0]    gnt;
  logic [31:0]   add_a, add_b;
  logic          add_cin;
  logic [31:0]   add_s;
  logic          add_cout;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_sum;
  logic          rsp_cout;
  logic          busy;
`ifdef FA32_ARB_STATS_EN
  logic [15:0]   ovf_cnt;
`endif

  fa32_pipe_arb #(.LAT(LAT), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .gnt       (gnt),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef FA32_ARB_STATS_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External adder: samples add_* every edge, result valid LAT edges later.
  logic [32:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign add_s    = apipe[LAT-1][31:0];
  assign add_cout = apipe[LAT-1][32];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_ovf     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id",   64'(rsp_id),   64'(e.id));
        check("rsp_sum",  64'(rsp_sum),  64'(e.sum));
        check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
        check("rsp_cyc",  64'(cyc),      64'(e.cyc));
        if (e.cout && exp_ovf < 16'hFFFF) exp_ovf++;
      end
    end
  end

  task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    req_cin[k]        = c;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 4; k++) set_ops(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // Drive one cycle of req/en, check the grant, queue the expected response.
  task automatic issue(input logic [3:0] r, input logic e, input logic [3:0] exp_gnt);
    int          k;
    logic [32:0] s;
    exp_t        x;
    @(negedge clk);
    req = r;
    en  = e;
    #1;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    k = -1;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) k = i;
    if (k >= 0) begin
      s = {1'b0, req_a[32*k +: 32]} + {1'b0, req_b[32*k +: 32]} + {32'd0, req_cin[k]};
      x.id   = 2'(k);
      x.sum  = s[31:0];
      x.cout = s[32];
      x.cyc  = cyc + LAT + 2;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    if (k >= 0) begin
      check("add_a",   64'(add_a),   64'(req_a[32*k +: 32]));
      check("add_b",   64'(add_b),   64'(req_b[32*k +: 32]));
      check("add_cin", 64'(add_cin), 64'(req_cin[k]));
      check("busy_issue", 64'(busy), 64'd1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req = '0;
    en  = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    check("busy_after_drain", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b0;
    #1;
    sb.delete();
    exp_ovf = 0;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_add_a",     64'(add_a),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;

    // Reset state, with requests already high to prove gnt is held off.
    rst_n   = 1'b0;
    en      = 1'b1;
    req     = 4'hF;
    req_a   = '0;
    req_b   = '0;
    req_cin = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt",       64'(gnt),       64'd0);
    check("reset_add_a",     64'(add_a),     64'd0);
    check("reset_add_b",     64'(add_b),     64'd0);
    check("reset_add_cin",   64'(add_cin),   64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_sum",   64'(rsp_sum),   64'd0);
    check("reset_rsp_id",    64'(rsp_id),    64'd0);
    check("reset_rsp_cout",  64'(rsp_cout),  64'd0);
    check("reset_busy",      64'(busy),      64'd0);
`ifdef FA32_ARB_STATS_EN
    check("reset_ovf_cnt",   64'(ovf_cnt),   64'd0);
`endif
    @(negedge clk);
    req   = '0;
    en    = 1'b0;
    rst_n = 1'b1;

    // Single operation from requester 2: 5 + 3 + 1 = 9, response 9 edges later.
    set_ops(2, 32'h0000_0005, 32'h0000_0003, 1'b1);
    issue(4'b0100, 1'b1, 4'b0100);
    idle();
    wait_empty(40);
    check("hold_rsp_id",  64'(rsp_id),  64'd2);
    check("hold_rsp_sum", 64'(rsp_sum), 64'd9);

    // All four requesting for 8 cycles from a fresh pointer.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      issue(4'hF, 1'b1, 4'(1 << (k % 4)));
    end
    idle();
    wait_empty(40);

    // Carry out of the top bit.
`ifdef FA32_ARB_STATS_EN
    check("ovf_before", 64'(ovf_cnt), 64'(exp_ovf));
`endif
    set_ops(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue(4'b0010, 1'b1, 4'b0010);
    idle();
    wait_empty(40);
    check("ovf_rsp_sum",  64'(rsp_sum),  64'd0);
    check("ovf_rsp_cout", 64'(rsp_cout), 64'd1);
`ifdef FA32_ARB_STATS_EN
    check("ovf_after", 64'(ovf_cnt), 64'(exp_ovf));
`endif

    // Three issues, then en low: drain ignores en until the pipe is empty.
    rand_ops();
    issue(4'hF, 1'b1, 4'b0100);
    issue(4'hF, 1'b1, 4'b1000);
    issue(4'hF, 1'b1, 4'b0001);
    issue(4'hF, 1'b0, 4'b0000);
    for (int k = 0; k < 4; k++) issue(4'hF, 1'b1, 4'b0000);
    idle();
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid && sb.size() == 0) found = 1'b1;
    end
    check("third_rsp_seen", 64'(found), 64'd1);
    check("busy_at_last_rsp", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    check("busy_after_last_rsp", 64'(busy),      64'd0);
    check("rsp_valid_pulse",     64'(rsp_valid), 64'd0);

    // Reset with five operations in flight: nothing may come back.
    rand_ops();
    issue(4'hF, 1'b1, 4'b0010);
    issue(4'hF, 1'b1, 4'b0100);
    issue(4'hF, 1'b1, 4'b1000);
    issue(4'hF, 1'b1, 4'b0001);
    issue(4'hF, 1'b1, 4'b0010);
    do_reset();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      check("rsp_after_reset", 64'(rsp_valid), 64'd0);
    end
    rand_ops();
    issue(4'hF, 1'b1, 4'b0001);
    idle();
    wait_empty(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
